avalon_bridge_arbiter: RTL and testbench

AVALON_BRIDGE_ARBITER -- requirements
Module: avalon_bridge_arbiter

---
 rtl/avalon_bridge_arbiter_if.sv | 56 +++++
 rtl/avalon_bridge_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_avalon_bridge_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_bridge_arbiter_if.sv
// ---------------------------------------------------------------------------
// avalon_bridge_arbiter_if
// Purpose : bus bundle between two requesters, the arbiter and the ipbus_1G
//           bridge external interface.
// Signals :
//   req_read/req_write      [1:0]  per-requester strobes, held until acked
//   req_address             [63:0] requester i address in [32i+31:32i]
//   req_byte_enable         [7:0]  requester i byte enables in [4i+3:4i]
//   req_write_data          [63:0] requester i write data in [32i+31:32i]
//   req_acknowledge         [1:0]  one-cycle completion pulse
//   req_error               [1:0]  qualifies req_acknowledge
//   req_read_data           [31:0] shared read data
//   bridge_read/bridge_write       strobes to the bridge
//   bridge_address/_byte_enable/_write_data  captured request fields
//   bridge_acknowledge, bridge_read_data     bridge completion and data
// Modports: slave = arbiter side, master = environment (requesters + bridge)
// ---------------------------------------------------------------------------
interface avalon_bridge_arbiter_if;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BEW   = 4;

    logic [N_REQ-1:0]     req_read;
    logic [N_REQ-1:0]     req_write;
    logic [N_REQ*AW-1:0]  req_address;
    logic [N_REQ*BEW-1:0] req_byte_enable;
    logic [N_REQ*DW-1:0]  req_write_data;
    logic [N_REQ-1:0]     req_acknowledge;
    logic [N_REQ-1:0]     req_error;
    logic [DW-1:0]        req_read_data;

    logic                 bridge_read;
    logic                 bridge_write;
    logic [AW-1:0]        bridge_address;
    logic [BEW-1:0]       bridge_byte_enable;
    logic [DW-1:0]        bridge_write_data;
    logic                 bridge_acknowledge;
    logic [DW-1:0]        bridge_read_data;

    modport slave (
        input  req_read, req_write, req_address, req_byte_enable, req_write_data,
        output req_acknowledge, req_error, req_read_data,
        output bridge_read, bridge_write, bridge_address, bridge_byte_enable,
               bridge_write_data,
        input  bridge_acknowledge, bridge_read_data
    );

    modport master (
        output req_read, req_write, req_address, req_byte_enable, req_write_data,
        input  req_acknowledge, req_error, req_read_data,
        input  bridge_read, bridge_write, bridge_address, bridge_byte_enable,
               bridge_write_data,
        output bridge_acknowledge, bridge_read_data
    );
endinterface

// File: rtl/avalon_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bridge_arbiter
// Purpose : round-robin arbiter that funnels two requesters onto a single
//           ipbus_1G bridge port, one outstanding transaction at a time,
//           with a per-transaction acknowledge timeout.
// Ports   :
//   clk125   in   single clock, rising edge
//   rst_125  in   synchronous active-high reset
//   bus      slave modport of avalon_bridge_arbiter_if (requester + bridge)
//   busy     out  high whenever the FSM is not in IDLE
//   owner    out  index of the last granted requester
// Parameters:
//   TIMEOUT_CYCLES  ISSUE cycles to wait for bridge_acknowledge (2..65535)
//   ERR_DATA        read data returned on aborted or illegal accesses
// ---------------------------------------------------------------------------
module avalon_bridge_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                    clk125,
    input  logic                    rst_125,
    avalon_bridge_arbiter_if.slave  bus,
    output logic                    busy,
    output logic                    owner
);
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BEW   = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BEW-1:0]   be_q, be_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Grant decode: lone requester wins, contention goes to the non-owner.
    logic [1:0]     pending;
    logic           grant_idx;
    logic [1:0]     grant_mask;
    logic [1:0]     owner_mask;
    logic           grant_rd;
    logic           grant_wr;
    logic [AW-1:0]  grant_addr;
    logic [BEW-1:0] grant_be;
    logic [DW-1:0]  grant_wdata;

    always_comb begin
        pending = bus.req_read | bus.req_write;
        if (pending == 2'b11) begin
            grant_idx = ~owner_q;
        end else begin
            grant_idx = pending[1];
        end
        grant_mask  = grant_idx ? 2'b10 : 2'b01;
        owner_mask  = owner_q   ? 2'b10 : 2'b01;
        grant_rd    = bus.req_read[grant_idx];
        grant_wr    = bus.req_write[grant_idx];
        grant_addr  = grant_idx ? bus.req_address[63:32]    : bus.req_address[31:0];
        grant_be    = grant_idx ? bus.req_byte_enable[7:4]  : bus.req_byte_enable[3:0];
        grant_wdata = grant_idx ? bus.req_write_data[63:32] : bus.req_write_data[31:0];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ack_d   = 2'b00;
        err_d   = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                // bridge_acknowledge is deliberately not looked at here.
                if (pending != 2'b00) begin
                    owner_d = grant_idx;
                    addr_d  = grant_addr;
                    be_d    = grant_be;
                    wdata_d = grant_wdata;
                    cnt_d   = '0;
                    if (grant_rd && grant_wr) begin
                        // Read+write together is illegal: never touches the bridge.
                        state_d = ST_DONE;
                        ack_d   = grant_mask;
                        err_d   = grant_mask;
                        rdata_d = ERR_DATA;
                    end else begin
                        state_d = ST_ISSUE;
                        rd_d    = grant_rd;
                        wr_d    = grant_wr;
                    end
                end
            end

            ST_ISSUE: begin
                // Acknowledge wins over a timeout landing in the same cycle.
                if (bus.bridge_acknowledge) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = owner_mask;
                    rdata_d = rd_q ? bus.bridge_read_data : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = owner_mask;
                    err_d   = owner_mask;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // One-cycle completion; returning to IDLE stops a held request
            // from being re-granted in the same breath.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk125) begin
        if (rst_125) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b1;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.bridge_read        = rd_q;
    assign bus.bridge_write       = wr_q;
    assign bus.bridge_address     = addr_q;
    assign bus.bridge_byte_enable = be_q;
    assign bus.bridge_write_data  = wdata_q;
    assign bus.req_acknowledge    = ack_q;
    assign bus.req_error          = err_q;
    assign bus.req_read_data      = rdata_q;
    assign busy                   = busy_q;
    assign owner                  = owner_q;

endmodule

// File: tb/tb_avalon_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_bridge_arbiter
// Purpose : self-checking bench for avalon_bridge_arbiter. Expectations come
//           from a transaction-level model: grant choice from the pending set
//           and last owner, strobe length from the ack delay clipped at the
//           timeout, and completion data from the operation kind.
// ---------------------------------------------------------------------------
module tb_avalon_bridge_arbiter;
    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk125 = 1'b0;
    logic rst_125;
    logic busy;
    logic owner;

    int n_checks = 0;
    int n_pass   = 0;
    logic m_owner = 1'b1;

    avalon_bridge_arbiter_if bus ();

    avalon_bridge_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk125  (clk125),
        .rst_125 (rst_125),
        .bus     (bus),
        .busy    (busy),
        .owner   (owner)
    );

    always #4 clk125 = ~clk125;

    // Advance to just after the next rising edge: outputs are stable, inputs
    // driven now are sampled at the following edge.
    task automatic tick;
        @(posedge clk125);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst_125 = 1'b1;
        bus.req_read = '0; bus.req_write = '0;
        bus.req_address = '0; bus.req_byte_enable = '0; bus.req_write_data = '0;
        bus.bridge_acknowledge = 1'b0; bus.bridge_read_data = '0;
        repeat (cycles) tick();
        rst_125 = 1'b0;
        m_owner = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset(2);
        n_checks++; if ({bus.bridge_read, bus.bridge_write} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {bus.bridge_read, bus.bridge_write}); else n_pass++;
        n_checks++; if ({bus.req_acknowledge, bus.req_error} !== 4'b0000) $display("FAIL reset_ack_err: got %b want 0000", {bus.req_acknowledge, bus.req_error}); else n_pass++;
        n_checks++; if ({busy, owner} !== 2'b01) $display("FAIL reset_busy_owner: got %b want 01", {busy, owner}); else n_pass++;
        n_checks++; if (bus.req_read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.req_read_data); else n_pass++;
        n_checks++; if ({bus.bridge_address, bus.bridge_byte_enable, bus.bridge_write_data} !== 68'h0) $display("FAIL reset_fields: got %h want 0", {bus.bridge_address, bus.bridge_byte_enable, bus.bridge_write_data}); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy); else n_pass++;
    endtask

    // One complete transaction starting in an IDLE cycle. ack_dly is the ISSUE
    // cycle index (0-based) in which the bridge acknowledges; >= TO never acks.
    task automatic run_txn(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input int unsigned ack_dly, input logic [31:0] ack_data);
        logic [1:0]  pend, gmask, e_strobe;
        logic        g, illegal, e_err;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
        logic [63:0] wd;
        logic [7:0]  be;
        int unsigned n_strobe;

        pend    = rd | wr;
        g       = (pend == 2'b11) ? ~m_owner : pend[1];
        gmask   = g ? 2'b10 : 2'b01;
        illegal = rd[g] & wr[g];
        wd      = {$urandom, $urandom};
        be      = 8'($urandom);
        e_addr  = g ? a1 : a0;
        e_be    = g ? be[7:4] : be[3:0];
        e_wdata = g ? wd[63:32] : wd[31:0];
        e_strobe = rd[g] ? 2'b10 : 2'b01;
        if (illegal) begin
            n_strobe = 0; e_err = 1'b1; e_rdata = ERR;
        end else if (ack_dly < TO) begin
            n_strobe = ack_dly + 1; e_err = 1'b0; e_rdata = rd[g] ? ack_data : 32'h0;
        end else begin
            n_strobe = TO; e_err = 1'b1; e_rdata = ERR;
        end

        bus.req_read = rd; bus.req_write = wr;
        bus.req_address = {a1, a0}; bus.req_byte_enable = be; bus.req_write_data = wd;
        bus.bridge_acknowledge = 1'b0;
        tick();

        for (int unsigned c = 0; c < n_strobe; c++) begin
            n_checks++; if ({bus.bridge_read, bus.bridge_write} !== e_strobe) $display("FAIL %s strobe c%0d: got %b want %b", tag, c, {bus.bridge_read, bus.bridge_write}, e_strobe); else n_pass++;
            n_checks++; if ({bus.bridge_address, bus.bridge_byte_enable, bus.bridge_write_data} !== {e_addr, e_be, e_wdata}) $display("FAIL %s fields c%0d: got %h want %h", tag, c, {bus.bridge_address, bus.bridge_byte_enable, bus.bridge_write_data}, {e_addr, e_be, e_wdata}); else n_pass++;
            n_checks++; if (bus.req_acknowledge !== 2'b00) $display("FAIL %s early_ack c%0d: got %b want 00", tag, c, bus.req_acknowledge); else n_pass++;
            if (c == 1) begin
                // Requests changing mid-transaction must not disturb it.
                bus.req_address = {$urandom, $urandom};
                bus.req_write_data = {$urandom, $urandom};
                bus.req_byte_enable = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    bus.req_read = '0; bus.req_write = '0;
                end
            end
            bus.bridge_acknowledge = (c == ack_dly);
            bus.bridge_read_data = (c == ack_dly) ? ack_data : $urandom;
            tick();
        end

        // DONE cycle; a stray bridge ack here must be ignored.
        bus.bridge_acknowledge = 1'($urandom);
        bus.bridge_read_data = $urandom;
        n_checks++; if (bus.req_acknowledge !== gmask) $display("FAIL %s ack: got %b want %b", tag, bus.req_acknowledge, gmask); else n_pass++;
        n_checks++; if (bus.req_error !== (e_err ? gmask : 2'b00)) $display("FAIL %s err: got %b want %b", tag, bus.req_error, e_err ? gmask : 2'b00); else n_pass++;
        n_checks++; if (bus.req_read_data !== e_rdata) $display("FAIL %s rdata: got %h want %h", tag, bus.req_read_data, e_rdata); else n_pass++;
        n_checks++; if ({bus.bridge_read, bus.bridge_write, busy} !== 3'b001) $display("FAIL %s done_state: got %b want 001", tag, {bus.bridge_read, bus.bridge_write, busy}); else n_pass++;
        bus.req_read = '0; bus.req_write = '0;
        tick();

        n_checks++; if ({bus.req_acknowledge, bus.req_error, busy} !== 5'b00000) $display("FAIL %s idle: got %b want 00000", tag, {bus.req_acknowledge, bus.req_error, busy}); else n_pass++;
        n_checks++; if (owner !== g) $display("FAIL %s owner: got %b want %b", tag, owner, g); else n_pass++;
        n_checks++; if (bus.req_read_data !== e_rdata) $display("FAIL %s rdata_hold: got %h want %h", tag, bus.req_read_data, e_rdata); else n_pass++;
        bus.bridge_acknowledge = 1'b0;
        m_owner = g;
    endtask

    task automatic test_round_robin;
        logic [31:0] a0, a1, d0, d1;
        apply_reset(1);
        a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
        bus.req_read = 2'b11; bus.req_address = {a1, a0};
        tick();
        n_checks++; if ({owner, bus.bridge_address} !== {1'b0, a0}) $display("FAIL rr_first: got %h want %h", {owner, bus.bridge_address}, {1'b0, a0}); else n_pass++;
        bus.bridge_acknowledge = 1'b1; bus.bridge_read_data = d0;
        tick();
        n_checks++; if ({bus.req_acknowledge, bus.req_read_data} !== {2'b01, d0}) $display("FAIL rr_done0: got %h want %h", {bus.req_acknowledge, bus.req_read_data}, {2'b01, d0}); else n_pass++;
        bus.req_read = 2'b10; bus.bridge_acknowledge = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle: busy got %b want 0", busy); else n_pass++;
        tick();
        n_checks++; if ({owner, bus.bridge_read, bus.bridge_address} !== {2'b11, a1}) $display("FAIL rr_second: got %h want %h", {owner, bus.bridge_read, bus.bridge_address}, {2'b11, a1}); else n_pass++;
        bus.bridge_acknowledge = 1'b1; bus.bridge_read_data = d1;
        tick();
        n_checks++; if ({bus.req_acknowledge, bus.req_read_data} !== {2'b10, d1}) $display("FAIL rr_done1: got %h want %h", {bus.req_acknowledge, bus.req_read_data}, {2'b10, d1}); else n_pass++;
        bus.req_read = '0; bus.bridge_acknowledge = 1'b0;
        tick();
        m_owner = 1'b1;
    endtask

    task automatic test_reset_in_issue;
        bus.req_write = 2'b01; bus.req_address = {$urandom, $urandom};
        tick();
        n_checks++; if (bus.bridge_write !== 1'b1) $display("FAIL rst_issue_strobe: got %b want 1", bus.bridge_write); else n_pass++;
        tick();
        rst_125 = 1'b1; bus.req_write = '0;
        tick();
        rst_125 = 1'b0; bus.bridge_acknowledge = 1'b1; bus.bridge_read_data = $urandom;
        n_checks++; if ({bus.bridge_read, bus.bridge_write, bus.req_acknowledge, busy, owner} !== 6'b000001) $display("FAIL rst_issue_abort: got %b want 000001", {bus.bridge_read, bus.bridge_write, bus.req_acknowledge, busy, owner}); else n_pass++;
        n_checks++; if (bus.req_read_data !== 32'h0) $display("FAIL rst_issue_rdata: got %h want 0", bus.req_read_data); else n_pass++;
        tick();
        bus.bridge_acknowledge = 1'b0;
        n_checks++; if ({bus.req_acknowledge, bus.req_error, busy} !== 5'b00000) $display("FAIL rst_issue_late_ack: got %b want 00000", {bus.req_acknowledge, bus.req_error, busy}); else n_pass++;
        m_owner = 1'b1;
    endtask

    // Requester 0 holds its read; each grant acks in its 2nd ISSUE cycle and
    // the ack is left high through DONE and IDLE as a late/spurious ack.
    task automatic test_back_to_back;
        logic [31:0] dk;
        bus.req_read = 2'b01; bus.req_write = '0; bus.req_address = {$urandom, $urandom};
        bus.bridge_acknowledge = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dk = $urandom;
            tick();
            bus.bridge_acknowledge = 1'b0;
            n_checks++; if ({bus.bridge_read, owner, bus.req_acknowledge} !== 4'b1000) $display("FAIL b2b%0d issue_a: got %b want 1000", k, {bus.bridge_read, owner, bus.req_acknowledge}); else n_pass++;
            tick();
            n_checks++; if ({bus.bridge_read, bus.req_acknowledge} !== 3'b100) $display("FAIL b2b%0d issue_b: got %b want 100", k, {bus.bridge_read, bus.req_acknowledge}); else n_pass++;
            bus.bridge_acknowledge = 1'b1; bus.bridge_read_data = dk;
            tick();
            n_checks++; if ({bus.req_acknowledge, bus.req_read_data} !== {2'b01, dk}) $display("FAIL b2b%0d done: got %h want %h", k, {bus.req_acknowledge, bus.req_read_data}, {2'b01, dk}); else n_pass++;
            tick();
            n_checks++; if ({busy, bus.req_acknowledge} !== 3'b000) $display("FAIL b2b%0d idle: got %b want 000", k, {busy, bus.req_acknowledge}); else n_pass++;
        end
        bus.req_read = '0; bus.bridge_acknowledge = 1'b0;
        tick();
        n_checks++; if ({busy, bus.req_acknowledge} !== 3'b000) $display("FAIL b2b_end: got %b want 000", {busy, bus.req_acknowledge}); else n_pass++;
        m_owner = 1'b0;
    endtask

    task automatic test_random(input int n);
        logic [1:0] rd, wr;
        int unsigned op;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 2; r++) begin
                op = $urandom_range(0, 6);
                rd[r] = (op == 2) || (op == 3) || (op == 6);
                wr[r] = (op == 4) || (op == 5) || (op == 6);
            end
            if ((rd | wr) == 2'b00) rd[1'($urandom_range(0, 1))] = 1'b1;
            run_txn("random", rd, wr, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
        end
    endtask

    initial begin
        test_reset();
        run_txn("read_r0",      2'b01, 2'b00, 32'h10, 32'h0, 2,  32'h1234_5678);
        run_txn("timeout_w1",   2'b00, 2'b10, 32'h0, 32'h20, 99, 32'h0);
        run_txn("illegal_r0",   2'b01, 2'b01, 32'h30, 32'h0, 0,  32'h0);
        run_txn("ack_at_limit", 2'b10, 2'b00, 32'h0, 32'h40, TO - 1, 32'hA5A5_5A5A);
        test_round_robin();
        test_reset_in_issue();
        test_back_to_back();
        test_random(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
